// File: rtl/async_sink.sv
// Clock-domain sink for a 2-phase micropipeline: synchronises req_in, captures tokens into a
// first-word-fall-through FIFO and acknowledges upstream. Define ASYNC_SINK_TOKCNT_EN to add tok_cnt.
module async_sink #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_in,
  input  logic [2:0] data_in,
  output logic       ack_out,
  output logic [2:0] data_out,
  output logic       valid_out,
  input  logic       ready_in
`ifdef ASYNC_SINK_TOKCNT_EN
  ,
  output logic [7:0] tok_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, CAPT} state_t;

  logic          req_s1_q, req_s2_q;
  logic          ack_q, ack_d;
  state_t        state_q, state_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [2:0]    mem_q [DEPTH];
  logic [2:0]    mem_d [DEPTH];
  logic          pending, empty, full, do_push, do_pop;

  assign pending = req_s2_q ^ ack_q;
  assign empty   = (wptr_q == rptr_q);
  // Same slot index with opposite wrap bit means the writer has lapped the reader.
  assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign do_push = (state_q == CAPT);
  assign do_pop  = !empty && ready_in;

  assign ack_out   = ack_q;
  assign valid_out = !empty;
  assign data_out  = empty ? 3'b000 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mem_d   = mem_q;
    if (state_q == CAPT) begin
      mem_d[wptr_q[AW-1:0]] = data_in;
      ack_d                 = ~ack_q;
      wptr_d                = wptr_q + {{AW{1'b0}}, 1'b1};
      state_d               = IDLE;
    end else if (pending && !full) begin
      // Full is judged on current pointers, so a pop on this edge only frees CAPT next edge.
      state_d = CAPT;
    end
    if (do_pop) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_s1_q <= 1'b0;
      req_s2_q <= 1'b0;
      ack_q    <= 1'b0;
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      mem_q    <= '{default: '0};
    end else begin
      req_s1_q <= req_in;
      req_s2_q <= req_s1_q;
      ack_q    <= ack_d;
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      mem_q    <= mem_d;
    end
  end

`ifdef ASYNC_SINK_TOKCNT_EN
  logic [7:0] tok_cnt_q, tok_cnt_d;

  always_comb begin
    tok_cnt_d = tok_cnt_q;
    if (do_push) tok_cnt_d = tok_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tok_cnt_q <= 8'd0;
    else        tok_cnt_q <= tok_cnt_d;
  end

  assign tok_cnt = tok_cnt_q;
`endif

endmodule

// File: tb/tb_async_sink.sv
// Scoreboard bench for async_sink: directed token sequences push expected data, a negedge
// monitor pops and compares every word the consumer accepts.
module tb_async_sink;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_in = 1'b0;
  logic [2:0] data_in = 3'b000;
  logic       ack_out;
  logic [2:0] data_out;
  logic       valid_out;
  logic       ready_in = 1'b0;
`ifdef ASYNC_SINK_TOKCNT_EN
  logic [7:0] tok_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_q[$];

  async_sink #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .data_in(data_in),
    .ack_out(ack_out), .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in)
`ifdef ASYNC_SINK_TOKCNT_EN
    , .tok_cnt(tok_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (ack_out != req_in && n < 40) begin
      tick(1);
      n++;
    end
    if (n >= 40) check("ack_timeout", 0, 1);
  endtask

  // Waits for the previous token's acknowledge, then launches a new one.
  task automatic send(input logic [2:0] d);
    wait_ack();
    data_in = d;
    req_in  = ~req_in;
    exp_q.push_back(d);
  endtask

  task automatic drain();
    int n = 0;
    wait_ack();
    ready_in = 1'b1;
    while (valid_out && n < 40) begin
      tick(1);
      n++;
    end
    ready_in = 1'b0;
    if (n >= 40) check("drain_timeout", 0, 1);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in) begin
      if (exp_q.size() == 0) check("mon_unexpected_pop", 1, 0);
      else check("mon_data", data_out, exp_q.pop_front());
    end
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_ack", ack_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
`ifdef ASYNC_SINK_TOKCNT_EN
    check("rst_tok_cnt", tok_cnt, 0);
`endif
    rst_n = 1'b1;
    tick(2);

    // Single token latency
    data_in = 3'b101;
    req_in  = 1'b1;
    exp_q.push_back(3'b101);
    tick(3);
    check("single_ack_e3", ack_out, 0);
    check("single_valid_e3", valid_out, 0);
    tick(1);
    check("single_ack_e4", ack_out, 1);
    check("single_valid_e4", valid_out, 1);
    check("single_data_e4", data_out, 5);
`ifdef ASYNC_SINK_TOKCNT_EN
    check("single_tok_cnt", tok_cnt, 1);
`endif
    drain();

    // Back-pressure: fifth token stalls until a pop frees a slot
    for (int i = 1; i <= 5; i++) send(3'(i));
    tick(12);
    check("bp_ack_withheld", int'(ack_out != req_in), 1);
    check("bp_valid", valid_out, 1);
    check("bp_head", data_out, 1);
    ready_in = 1'b1;
    tick(1);
    ready_in = 1'b0;
    check("bp_ack_after_pop", int'(ack_out != req_in), 1);
    tick(1);
    check("bp_ack_pop_plus1", int'(ack_out != req_in), 1);
    tick(1);
    check("bp_ack_pop_plus2", int'(ack_out == req_in), 1);
    check("bp_head_after_pop", data_out, 2);
    drain();

    // Streaming with the consumer always ready
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) send(3'(i));
    drain();

    // Simultaneous push and pop at occupancy 2
    send(3'd3);
    send(3'd6);
    wait_ack();
    tick(2);
    check("pp_head_before", data_out, 3);
    data_in = 3'd7;
    req_in  = ~req_in;
    exp_q.push_back(3'd7);
    tick(3);
    ready_in = 1'b1;
    tick(1);
    ready_in = 1'b0;
    check("pp_ack", int'(ack_out == req_in), 1);
    check("pp_head_advanced", data_out, 6);
    ready_in = 1'b1;
    tick(1);
    ready_in = 1'b0;
    check("pp_occ2_valid", valid_out, 1);
    check("pp_occ2_head", data_out, 7);
    ready_in = 1'b1;
    tick(1);
    ready_in = 1'b0;
    check("pp_empty_valid", valid_out, 0);
    check("pp_empty_data", data_out, 0);
    check("pp_queue_empty", exp_q.size(), 0);

    // Reset mid-stream with three entries buffered
    send(3'd1);
    send(3'd2);
    send(3'd4);
    wait_ack();
    tick(2);
    check("mid_valid_before", valid_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_ack", ack_out, 0);
    exp_q.delete();
    req_in  = 1'b1;
    data_in = 3'd5;
    tick(2);
    rst_n = 1'b1;
    exp_q.push_back(3'd5);
    tick(3);
    check("mid_rel_ack_e3", ack_out, 0);
    tick(1);
    check("mid_rel_ack_e4", ack_out, 1);
    check("mid_rel_data", data_out, 5);
    drain();
    tick(6);
    check("mid_single_token", valid_out, 0);

`ifdef ASYNC_SINK_TOKCNT_EN
    // Counter wrap across 257 writes
    rst_n = 1'b0;
    exp_q.delete();
    tick(2);
    req_in = 1'b0;
    rst_n  = 1'b1;
    tick(2);
    ready_in = 1'b1;
    for (int i = 0; i < 257; i++) send(3'(i));
    drain();
    check("tok_cnt_wrap", tok_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/async_sink.md
ASYNC_SINK -- requirements
Module: async_sink

Interface
REQ-001 SHALL have parameter: DEPTH, 4, FIFO entries (power of 2, >=2).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req_in  input  1  2-phase request from last micropipeline stage; each transition = one token.
REQ-005 SHALL have port: data_in  input  3  bundled data, stable from req_in transition until matching ack_out transition.
REQ-006 SHALL have port: ack_out  output  1  2-phase acknowledge to last stage.
REQ-007 SHALL have port: data_out  output  3  FIFO head to clocked consumer.
REQ-008 SHALL have port: valid_out  output  1  FIFO non-empty.
REQ-009 SHALL have port: ready_in  input  1  consumer accepts head when valid_out=1.

Function
REQ-010 SHALL synchronize req_in through two flops (req_s1 -> req_s2); no other logic on req_s1.
REQ-011 SHALL define pending = req_s2 XOR ack_out.
REQ-012 SHALL implement FSM IDLE, CAPT; IDLE -> CAPT when pending=1 and FIFO not full at that edge; else stay IDLE.
REQ-013 SHALL in CAPT: write data_in into FIFO tail, toggle ack_out, return to IDLE, all on the same edge.
REQ-014 SHALL sample data_in only on the CAPT write edge.
REQ-015 SHALL give latency: req_in toggle before edge 1 -> req_s2 at edge 2, CAPT at edge 3, write + ack_out toggle + valid_out=1 at edge 4.
REQ-016 SHALL sustain at most one token per 2 clocks after synchronization; a new token is not detected until req_s2 differs from the toggled ack_out.
REQ-017 SHALL withhold ack_out while full, stalling upstream; FIFO never overflows, no data dropped.
REQ-018 SHALL present the FIFO head first-word-fall-through: valid_out = not empty, data_out = head entry, data_out = 3'b000 whenever valid_out=0.
REQ-019 SHALL pop on an edge where valid_out=1 and ready_in=1; ready_in ignored when empty.
REQ-020 SHALL on simultaneous push and pop keep occupancy unchanged; when empty, push visible only from the next cycle (no bypass).
REQ-021 SHALL use read/write pointers with an extra wrap bit; full = equal index with differing wrap bit, empty = pointers equal; wrap DEPTH-1 -> 0.
REQ-022 SHALL evaluate full in IDLE before any same-edge pop; a pop while full lets CAPT proceed on the following edge.

Reset
REQ-023 SHALL on rst_n=0 immediately force: req_s1=req_s2=0, ack_out=0, FSM=IDLE, pointers=0, valid_out=0, data_out=3'b000, storage=0.
REQ-024 SHALL treat req_in=1 at reset release as one pending token (2-phase parity vs ack_out=0), captured per REQ-015.
REQ-025 SHALL on reset mid-operation discard FIFO contents and any in-flight CAPT; no partial write survives.

Configuration
REQ-026 SHALL, with ASYNC_SINK_TOKCNT_EN defined, add output tok_cnt (8 bits, reset 0) incrementing on each FIFO write, wrapping 255 -> 0.
REQ-027 SHALL, without ASYNC_SINK_TOKCNT_EN, omit the tok_cnt port and counter; all other behaviour identical.

Verification
REQ-028 SHALL cover single token: reset, req_in 0->1 with data_in=3'b101, ready_in=0 -> ack_out 1 and valid_out=1 with data_out=3'b101 at edge 4.
REQ-029 SHALL cover back-pressure: ready_in=0, send 5 tokens 1..5 -> 4 acks, 5th ack withheld; ready_in=1 for one cycle -> pop 1, 5th ack 2 edges later, order 2,3,4,5.
REQ-030 SHALL cover streaming: ready_in=1, upstream toggles immediately on each ack, 8 tokens 0..7 -> all delivered in order, no duplicates, FIFO never full.
REQ-031 SHALL cover simultaneous push/pop at occupancy 2 -> occupancy stays 2, head advances.
REQ-032 SHALL cover reset mid-stream: assert rst_n=0 with 3 entries -> valid_out=0, data_out=0, ack_out=0 immediately; release with req_in=1 -> one token captured.
REQ-033 SHALL cover ASYNC_SINK_TOKCNT_EN: 257 tokens -> tok_cnt=1; build without macro -> compiles, no tok_cnt port.
